fp_addsub_pipe: RTL and testbench
=================================

// Module: fp_addsub_pipe
// PURPOSE
//  Parametrised, 3-stage pipelined IEEE-style floating-point adder/subtractor, with default format binary16.
//  Handles both signs and both operations, normalises after cancellation, and rounds to nearest, ties to even.
//  Uses valid/ready handshakes on input and output, with backpressure.
//  Sits between operand staging and the result writeback in the arithmetic datapath.
// PARAMETERS
//  EXP_W  5   exponent field width; bias = 2^(EXP_W-1)-1
//  MAN_W  10  stored mantissa width (hidden bit excluded); word width W = 1+EXP_W+MAN_W
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-low reset
//  in_valid   in   1   operands a, b, op are valid
//  in_ready   out  1   block accepts operands this cycle
//  a          in   W   operand A
//  b          in   W   operand B
//  op         in   1   0: a+b, 1: a-b (b sign inverted before align)
//  out_valid  out  1   x is valid
//  out_ready  in   1   consumer takes x this cycle
//  x          out  W   rounded result
//  ovf        out  1   result overflowed (qualified by out_valid)
// BEHAVIOUR
//  - Reset values: all stage valids = 0, out_valid = 0, x = 0, ovf = 0. in_ready = 1 after reset.
//  - Reset mid-operation discards all in-flight results; no partial output appears.
//  - Handshake: transfer on in_valid&in_ready or on out_valid&out_ready.
//  - Global stall: stall = out_valid & ~out_ready; in_ready = ~stall.
//  - During a stall every stage register holds.
//  - x, out_valid and ovf stay stable while stalled.
//  - Latency is exactly 3 cycles from accept to out_valid when not stalled. Throughput is 1 per cycle.
//  - S1 align:
//    - unpack the operands; the effective sign of b is b.sign^op
//    - swap so that |big| >= |small|, comparing {exp,man}
//    - right-shift the small significand by the exponent difference into {sig,G,R,S}
//    - shifted-out bits are ORed into S; a difference > MAN_W+3 leaves S only
//  - S2 add:
//    - if the signs are equal, add the significands; otherwise subtract small from big
//    - result is MAN_W+5 bits wide; the result sign is the sign of big
//  - S3 normalise/round/pack:
//    - on carry-out, shift right 1, fold the lost bit into S, exp+1
//    - otherwise shift left by LZC, exp-LZC
//    - round to nearest, ties to even, on G/R/S; mantissa round-up carry increments exp
//  - Exact cancellation (including x-x) gives +0.
//  - Zero inputs: exp==0 means zero; the mantissa is ignored (flush-to-zero).
//  - Underflow: final exp <= 0 flushes to signed zero. ovf is not set on underflow.
//  - Overflow: see CONFIGURATION.
// CONFIGURATION
//  Macro FP_ADDSUB_SPECIALS_EN.
//  - Defined: exp==all-ones is Inf/NaN.
//    - NaN in, or Inf-Inf, gives canonical quiet NaN {0,1..1,1,0..0} (0x7E00).
//    - Inf+finite passes the Inf through with its sign.
//    - Overflow gives signed Inf and ovf=1.
//  - Undefined: exp==all-ones is an ordinary finite exponent.
//    - Overflow past it saturates to {sign,1..1,1..1} with ovf=1.
//    - No NaN is ever produced.
// STRUCTURE
//  - Package fp_pkg:
//    - functions/localparams for EXP_W/MAN_W-derived widths and EXP_BIAS
//    - typedef fp_unpacked_t {sign, exp, sig-with-hidden-bit}
//    - the CANON_QNAN constant
//    - the unpack/pack helper functions
//  - Sub-module fp_lzc (parametrised leading-zero counter, WIDTH, combinational) is used in S3.
//  - The S2 significand adder reuses the existing ksa adder with BITS=MAN_W+5.
// TESTING (binary16 defaults)
//  1. a=0x3C00 b=0x4000 op=0 -> x=0x4200 (1+2=3), out_valid exactly 3 cycles after accept.
//  2. a=0x4200 b=0x4000 op=1 -> x=0x3C00; a=0x3C00 b=0x3C00 op=1 -> x=0x0000 (+0).
//  3. RNE: 0x3C00+0x1000 -> 0x3C00 (tie, even kept); 0x3C01+0x1000 -> 0x3C02 (tie, round up).
//  4. Overflow: 0x7BFF+0x7BFF.
//     - With the macro: x=0x7C00, ovf=1.
//     - Without the macro: x=0x7FFF (exactly representable), ovf=0.
//     - Without the macro, 0x7FFF+0x7FFF -> x=0x7FFF, ovf=1.
//  5. Backpressure: issue 4 back-to-back ops, hold out_ready=0 for 5 cycles.
//     in_ready drops, x is stable, all 4 results appear in order, none lost or duplicated.
//  6. Assert rst low with 3 ops in flight: out_valid=0 next edge; no stale result appears after release.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared floating-point helpers: derived widths, unpacked operand type,
// canonical quiet NaN and the pack/unpack functions used by fp_addsub_pipe.
package fp_pkg;

  localparam int EXP_W_DEF = 5;
  localparam int MAN_W_DEF = 10;
  localparam int MAX_EXP_W = 16;
  localparam int MAX_SIG_W = 64;

  localparam logic [15:0] CANON_QNAN = 16'h7E00;

  typedef struct packed {
    logic                 sign;
    logic [MAX_EXP_W-1:0] exp;
    logic [MAX_SIG_W-1:0] sig;
  } fp_unpacked_t;

  function automatic int word_w(input int e, input int m);
    return 1 + e + m;
  endfunction

  function automatic int exp_bias(input int e);
    return (1 << (e - 1)) - 1;
  endfunction

  // significand with hidden bit plus guard, round and sticky
  function automatic int guard_w(input int m);
    return m + 4;
  endfunction

  function automatic logic [63:0] canon_qnan(input int e, input int m);
    return ((64'd1 << (e + 1)) - 64'd1) << (m - 1);
  endfunction

  // exp==0 is zero: the mantissa is dropped and the hidden bit is clear
  function automatic fp_unpacked_t unpack(input logic [63:0] w, input int e, input int m);
    fp_unpacked_t u;
    logic [63:0]  ex;
    logic [63:0]  man;
    ex     = (w >> m) & ((64'd1 << e) - 64'd1);
    man    = w & ((64'd1 << m) - 64'd1);
    u.sign = w[e+m];
    u.exp  = MAX_EXP_W'(ex);
    u.sig  = (ex == 64'd0) ? 64'd0 : (man | (64'd1 << m));
    return u;
  endfunction

  function automatic logic [63:0] pack(input logic s, input logic [63:0] ex,
                                       input logic [63:0] man, input int e, input int m);
    return ({63'd0, s} << (e + m))
         | ((ex & ((64'd1 << e) - 64'd1)) << m)
         | (man & ((64'd1 << m) - 64'd1));
  endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input returns WIDTH.
module fp_lzc #(
  parameter  int WIDTH = 14,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] v,
  output logic [CW-1:0]    cnt
);

  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) cnt = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/ksa.sv
// Kogge-Stone parallel-prefix adder with carry-in.
module ksa #(
  parameter int BITS = 16
) (
  input  logic [BITS-1:0] a,
  input  logic [BITS-1:0] b,
  input  logic            cin,
  output logic [BITS-1:0] sum
);

  localparam int LVL = $clog2(BITS);

  logic [BITS-1:0] g, p, gn, pn;

  always_comb begin
    g    = a & b;
    p    = a ^ b;
    // carry-in folded into bit 0 so every prefix already includes it
    g[0] = g[0] | (p[0] & cin);
    gn   = g;
    pn   = p;
    for (int l = 0; l < LVL; l++) begin
      gn = g;
      pn = p;
      for (int i = (1 << l); i < BITS; i++) begin
        gn[i] = g[i] | (p[i] & g[i-(1<<l)]);
        pn[i] = p[i] & p[i-(1<<l)];
      end
      g = gn;
      p = pn;
    end
    sum = a ^ b ^ {g[BITS-2:0], cin};
  end

endmodule

// File: rtl/fp_addsub_pipe.sv
// 3-stage floating-point add/subtract (align, add, normalise/round) with valid/ready.
// Define FP_ADDSUB_SPECIALS_EN to treat exp==all-ones as Inf/NaN; otherwise it is finite.
module fp_addsub_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  input  logic                   op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   x,
  output logic                   ovf
);

  localparam int W  = word_w(EXP_W, MAN_W);
  localparam int GW = guard_w(MAN_W);
  localparam int LW = $clog2(GW + 1);
  localparam int EW = ((EXP_W > LW) ? EXP_W : LW) + 2;
`ifdef FP_ADDSUB_SPECIALS_EN
  localparam int MAX_E = (1 << EXP_W) - 2;
`else
  localparam int MAX_E = (1 << EXP_W) - 1;
`endif

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  fp_unpacked_t     ua, ub;
  logic             sign_b, swap, big_sign, small_sign;
  logic [EXP_W-1:0] big_exp, small_exp, diff;
  logic [MAN_W:0]   big_sig, small_sig;
  logic [GW-1:0]    small_ext, lost, aligned;
  logic             spec_hit;
  logic [W-1:0]     spec_x;

  always_comb begin
    ua         = unpack(64'(a), EXP_W, MAN_W);
    ub         = unpack(64'(b), EXP_W, MAN_W);
    sign_b     = ub.sign ^ op;
    swap       = {ub.exp, ub.sig} > {ua.exp, ua.sig};
    big_sign   = swap ? sign_b : ua.sign;
    small_sign = swap ? ua.sign : sign_b;
    big_exp    = swap ? ub.exp[EXP_W-1:0] : ua.exp[EXP_W-1:0];
    small_exp  = swap ? ua.exp[EXP_W-1:0] : ub.exp[EXP_W-1:0];
    big_sig    = swap ? ub.sig[MAN_W:0] : ua.sig[MAN_W:0];
    small_sig  = swap ? ua.sig[MAN_W:0] : ub.sig[MAN_W:0];
    diff       = big_exp - small_exp;
    small_ext  = {small_sig, 3'b000};
    if (int'(diff) > MAN_W + 3) begin
      lost       = '0;
      aligned    = '0;
      aligned[0] = |small_sig;
    end else begin
      lost       = small_ext & ~({GW{1'b1}} << diff);
      aligned    = small_ext >> diff;
      aligned[0] = aligned[0] | (|lost);
    end
  end

`ifdef FP_ADDSUB_SPECIALS_EN
  logic a_max, b_max, a_nan, b_nan;
  always_comb begin
    a_max    = &a[W-2:MAN_W];
    b_max    = &b[W-2:MAN_W];
    a_nan    = a_max & (|a[MAN_W-1:0]);
    b_nan    = b_max & (|b[MAN_W-1:0]);
    spec_hit = a_max | b_max;
    if (a_nan | b_nan | (a_max & b_max & (a[W-1] != sign_b)))
      spec_x = W'(canon_qnan(EXP_W, MAN_W));
    else if (a_max)
      spec_x = {a[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      spec_x = {sign_b, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
  end
`else
  assign spec_hit = 1'b0;
  assign spec_x   = '0;
`endif

  logic             s1_valid, s1_sign, s1_sub, s1_spec;
  logic [EXP_W-1:0] s1_exp;
  logic [MAN_W:0]   s1_big;
  logic [GW-1:0]    s1_small;
  logic [W-1:0]     s1_spec_x;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_sub    <= 1'b0;
      s1_spec   <= 1'b0;
      s1_exp    <= '0;
      s1_big    <= '0;
      s1_small  <= '0;
      s1_spec_x <= '0;
    end else if (!stall) begin
      s1_valid  <= in_valid;
      s1_sign   <= big_sign;
      s1_sub    <= big_sign ^ small_sign;
      s1_spec   <= spec_hit;
      s1_exp    <= big_exp;
      s1_big    <= big_sig;
      s1_small  <= aligned;
      s1_spec_x <= spec_x;
    end
  end

  // |big| >= |small|, so the difference never goes negative
  logic [GW:0] add_b, sum2;
  assign add_b = s1_sub ? ~{1'b0, s1_small} : {1'b0, s1_small};

  ksa #(.BITS(GW + 1)) u_ksa (
    .a   ({1'b0, s1_big, 3'b000}),
    .b   (add_b),
    .cin (s1_sub),
    .sum (sum2)
  );

  logic             s2_valid, s2_sign, s2_spec;
  logic [EXP_W-1:0] s2_exp;
  logic [GW:0]      s2_sum;
  logic [W-1:0]     s2_spec_x;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_spec   <= 1'b0;
      s2_exp    <= '0;
      s2_sum    <= '0;
      s2_spec_x <= '0;
    end else if (!stall) begin
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_spec   <= s1_spec;
      s2_exp    <= s1_exp;
      s2_sum    <= sum2;
      s2_spec_x <= s1_spec_x;
    end
  end

  logic [LW-1:0]        lzc;
  logic [GW-1:0]        norm;
  logic signed [EW-1:0] exp_base, exp_n, exp_f;
  logic                 round_up;
  logic [MAN_W+1:0]     rnd;
  logic [MAN_W-1:0]     man_f;
  logic [W-1:0]         x_d;
  logic                 ovf_d;

  fp_lzc #(.WIDTH(GW)) u_lzc (
    .v   (s2_sum[GW-1:0]),
    .cnt (lzc)
  );

  always_comb begin
    exp_base = EW'(s2_exp);
    if (s2_sum[GW]) begin
      norm  = {s2_sum[GW:2], s2_sum[1] | s2_sum[0]};
      exp_n = exp_base + EW'(1);
    end else begin
      norm  = s2_sum[GW-1:0] << lzc;
      exp_n = exp_base - EW'(lzc);
    end
    round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    rnd      = {1'b0, norm[GW-1:3]} + (MAN_W + 2)'(round_up);
    exp_f    = exp_n + EW'(rnd[MAN_W+1]);
    man_f    = rnd[MAN_W+1] ? rnd[MAN_W:1] : rnd[MAN_W-1:0];

    x_d   = '0;
    ovf_d = 1'b0;
    if (s2_spec) begin
      x_d = s2_spec_x;
    end else if (s2_sum == '0) begin
      x_d = '0;
    end else if (exp_f <= EW'(0)) begin
      x_d = {s2_sign, {(W-1){1'b0}}};
    end else if (exp_f > EW'(MAX_E)) begin
      ovf_d = 1'b1;
`ifdef FP_ADDSUB_SPECIALS_EN
      x_d   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`else
      x_d   = {s2_sign, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
`endif
    end else begin
      x_d = W'(pack(s2_sign, 64'(exp_f[EXP_W-1:0]), 64'(man_f), EXP_W, MAN_W));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      x         <= '0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        x   <= x_d;
        ovf <= ovf_d;
      end
    end
  end

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Directed-vector bench for fp_addsub_pipe (binary16): table of vectors plus
// backpressure and mid-flight reset sequences.
module tb_fp_addsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a, b;
  logic        op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x;
  logic        ovf;

  fp_addsub_pipe #(.EXP_W(5), .MAN_W(10)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        op;
    logic [15:0] x;
    logic        ovf;
    string       name;
  } vec_t;

  vec_t vecs[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp_v);
    end
  endtask

  task automatic add(input logic [15:0] va, input logic [15:0] vb, input logic vop,
                     input logic [15:0] vx, input logic vovf, input string nm);
    vec_t v;
    v.a = va; v.b = vb; v.op = vop; v.x = vx; v.ovf = vovf; v.name = nm;
    vecs.push_back(v);
  endtask

  // one transfer; lat counts edges from the accepting edge to out_valid
  task automatic do_op(input logic [15:0] ta, input logic [15:0] tb, input logic top,
                       output logic [15:0] rx, output logic rovf, output int lat);
    @(negedge clk);
    a = ta; b = tb; op = top; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    rx   = x;
    rovf = ovf;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] rx;
    logic        rovf;
    int          lat;
    logic [15:0] bp_a [4] = '{16'h3C00, 16'h4200, 16'h3C00, 16'h4000};
    logic [15:0] bp_b [4] = '{16'h4000, 16'h4000, 16'h3C00, 16'h4000};
    logic        bp_op[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [15:0] bp_x [4] = '{16'h4200, 16'h3C00, 16'h4000, 16'h4400};
    int          n_got, extra, prod_to, seen;

    add(16'h3C00, 16'h4000, 1'b0, 16'h4200, 1'b0, "one_plus_two");
    add(16'h4200, 16'h4000, 1'b1, 16'h3C00, 1'b0, "three_minus_two");
    add(16'h3C00, 16'h3C00, 1'b1, 16'h0000, 1'b0, "x_minus_x");
    add(16'h3C00, 16'h1000, 1'b0, 16'h3C00, 1'b0, "rne_tie_even");
    add(16'h3C01, 16'h1000, 1'b0, 16'h3C02, 1'b0, "rne_tie_up");
    add(16'h3C00, 16'h1001, 1'b0, 16'h3C01, 1'b0, "rne_above_tie");
    add(16'h3C00, 16'h0400, 1'b0, 16'h3C00, 1'b0, "far_shift_sticky");
    add(16'h3E00, 16'h3E00, 1'b0, 16'h4200, 1'b0, "carry_out");
    add(16'h3C00, 16'h4000, 1'b1, 16'hBC00, 1'b0, "neg_result");
    add(16'hBC00, 16'h3C00, 1'b1, 16'hC000, 1'b0, "neg_minus_pos");
    add(16'h3C00, 16'hBC00, 1'b0, 16'h0000, 1'b0, "cancel_add");
    add(16'h0000, 16'h4500, 1'b0, 16'h4500, 1'b0, "zero_plus_x");
    add(16'h0001, 16'h3C00, 1'b0, 16'h3C00, 1'b0, "flush_denorm");
    add(16'h0400, 16'h0401, 1'b1, 16'h8000, 1'b0, "underflow");
    add(16'h3C00, 16'h1001, 1'b1, 16'h3BFF, 1'b0, "sub_round");
`ifdef FP_ADDSUB_SPECIALS_EN
    add(16'h7BFF, 16'h7BFF, 1'b0, 16'h7C00, 1'b1, "ovf_inf");
    add(16'h7FFF, 16'h7FFF, 1'b0, 16'h7E00, 1'b0, "nan_in");
    add(16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 1'b0, "inf_pass");
    add(16'h7C00, 16'h7C00, 1'b1, 16'h7E00, 1'b0, "inf_minus_inf");
`else
    add(16'h7BFF, 16'h7BFF, 1'b0, 16'h7FFF, 1'b0, "max_exp_exact");
    add(16'h7FFF, 16'h7FFF, 1'b0, 16'h7FFF, 1'b1, "ovf_saturate");
    add(16'h7C00, 16'h3C00, 1'b0, 16'h7C00, 1'b0, "top_exp_finite");
    add(16'h7C00, 16'h7C00, 1'b1, 16'h0000, 1'b0, "top_exp_cancel");
`endif

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; op = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_x", x, 0);
    chk("reset_ovf", ovf, 0);
    chk("reset_in_ready", in_ready, 1);
    rst = 1'b1;

    foreach (vecs[i]) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].op, rx, rovf, lat);
      chk({vecs[i].name, "_x"}, rx, vecs[i].x);
      chk({vecs[i].name, "_ovf"}, rovf, vecs[i].ovf);
      chk({vecs[i].name, "_latency"}, lat, 3);
    end

    // backpressure: 4 back-to-back ops, consumer stalls for several cycles
    @(negedge clk);
    out_ready = 1'b0;
    n_got = 0; extra = 0; prod_to = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          int   w;
          logic acc;
          a = bp_a[i]; b = bp_b[i]; op = bp_op[i]; in_valid = 1'b1;
          w = 0;
          do begin
            #1 acc = in_ready;
            @(negedge clk);
            w++;
          end while (!acc && w < 40);
          if (!acc) prod_to = 1;
        end
        in_valid = 1'b0;
      end
      begin
        int          w;
        logic [15:0] held;
        w = 0;
        while (!out_valid && w < 20) begin
          @(negedge clk);
          w++;
        end
        held = x;
        chk("bp_first_result", held, bp_x[0]);
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          chk("bp_x_stable", x, held);
          chk("bp_in_ready_low", in_ready, 0);
          chk("bp_out_valid_held", out_valid, 1);
        end
        out_ready = 1'b1;
        w = 0;
        while (n_got < 4 && w < 40) begin
          if (out_valid) begin
            chk("bp_order", x, bp_x[n_got]);
            n_got++;
          end
          @(negedge clk);
          w++;
        end
        for (int k = 0; k < 4; k++) begin
          if (out_valid) extra++;
          @(negedge clk);
        end
      end
    join
    chk("bp_producer_accept", prod_to, 0);
    chk("bp_count", n_got, 4);
    chk("bp_no_duplicate", extra, 0);

    // reset with three operations in flight
    out_ready = 1'b1;
    a = 16'h3C00; b = 16'h4000; op = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h4200; b = 16'h4000; op = 1'b1;
    @(negedge clk);
    a = 16'h3E00; b = 16'h3E00; op = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("rst_pre_out_valid", out_valid, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_x", x, 0);
    @(negedge clk);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("rst_no_stale", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
